// File: rtl/neuron_fetch_stream_unit.sv
// Neuron fetch stream unit: takes one NUM_CHANNELS-wide cache beat, rotates it by the current
// beginning channel, buffers NUM_CHANNELS-1 words and streams filter_width+1 of them to the PE
// row over valid/ready. The beginning channel advances by a programmable stride on request.
// Optional build macro NFU_ZERO_PAD_EN adds pad_mask_i, which zeroes buffered words for padding.
module neuron_fetch_stream_unit #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 7,
    parameter int unsigned CH_BIT_WIDTH = 3,
    parameter int unsigned FW_BIT_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             layer_reset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] fetch_data_i,
    input  logic                             fetch_valid_i,
    output logic                             fetch_ready_o,
    input  logic                             channel_switch_en_i,
    input  logic [CH_BIT_WIDTH-1:0]          stride_i,
    input  logic [FW_BIT_WIDTH-1:0]          filter_width_i,
`ifdef NFU_ZERO_PAD_EN
    input  logic [NUM_CHANNELS-2:0]          pad_mask_i,
`endif
    output logic [DATA_WIDTH-1:0]            neuron_activation_o,
    output logic                             neuron_valid_o,
    input  logic                             neuron_ready_i,
    output logic                             neuron_last_o
);

    localparam int unsigned NumBuf = NUM_CHANNELS - 1;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                  state_q;
    logic [CH_BIT_WIDTH-1:0] begin_ch_q;
    logic [CH_BIT_WIDTH-1:0] begin_ch_next;
    logic [FW_BIT_WIDTH-1:0] fw_lat_q;
    logic [FW_BIT_WIDTH-1:0] fw_clamped;
    logic [FW_BIT_WIDTH-1:0] index_q;
    logic [FW_BIT_WIDTH-1:0] index_nxt;
    logic [DATA_WIDTH-1:0]   word_buf_q [NumBuf];
    logic [DATA_WIDTH-1:0]   rotated    [NumBuf];
    logic [DATA_WIDTH-1:0]   next_word;
    logic                    accept;

    assign fetch_ready_o = (state_q == StIdle);
    assign accept        = fetch_valid_i & fetch_ready_o;
    assign index_nxt     = index_q + FW_BIT_WIDTH'(1);

    // Rotate the incoming beat so slot k holds channel (begin_ch + k) mod NUM_CHANNELS.
    always_comb begin
        int unsigned ch;
        ch = 0;
        for (int unsigned k = 0; k < NumBuf; k++) begin
            ch = 32'(begin_ch_q) + k;
            if (ch >= NUM_CHANNELS) begin
                ch = ch - NUM_CHANNELS;
            end
            rotated[k] = fetch_data_i[ch*DATA_WIDTH +: DATA_WIDTH];
`ifdef NFU_ZERO_PAD_EN
            if (pad_mask_i[k]) begin
                rotated[k] = '0;
            end
`endif
        end
    end

    // Burst length clamp and next beginning channel (stride reduced modulo channel count).
    always_comb begin
        if (32'(filter_width_i) > NUM_CHANNELS - 2) begin
            fw_clamped = FW_BIT_WIDTH'(NUM_CHANNELS - 2);
        end else begin
            fw_clamped = filter_width_i;
        end
        begin_ch_next = CH_BIT_WIDTH'((32'(begin_ch_q) + (32'(stride_i) % NUM_CHANNELS))
                                      % NUM_CHANNELS);
    end

    // Select the buffered word that follows the current index.
    always_comb begin
        next_word = '0;
        for (int unsigned k = 0; k < NumBuf; k++) begin
            if (32'(index_nxt) == k) begin
                next_word = word_buf_q[k];
            end
        end
    end

    // Capture the rotated beat on accept; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_buf_q <= rotated;
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (layer_reset) begin
            state_q             <= StIdle;
            begin_ch_q          <= '0;
            index_q             <= '0;
            fw_lat_q            <= '0;
            neuron_activation_o <= '0;
            neuron_valid_o      <= 1'b0;
            neuron_last_o       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_valid_i) begin
                        fw_lat_q            <= fw_clamped;
                        index_q             <= '0;
                        neuron_activation_o <= rotated[0];
                        neuron_valid_o      <= 1'b1;
                        neuron_last_o       <= (fw_clamped == '0);
                        state_q             <= StStream;
                        // The current beat already used the old pointer.
                        if (channel_switch_en_i) begin
                            begin_ch_q <= begin_ch_next;
                        end
                    end
                end
                StStream: begin
                    if (neuron_ready_i) begin
                        if (index_q == fw_lat_q) begin
                            neuron_valid_o <= 1'b0;
                            neuron_last_o  <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            index_q             <= index_nxt;
                            neuron_activation_o <= next_word;
                            neuron_last_o       <= (index_nxt == fw_lat_q);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
